// File: rtl/conv_job_sequencer.sv
// conv_job_sequencer
//   Runs one convolution job on the full_conv datapath. It holds six
//   stride x stride signed kernels, pulses the datapath reset at job start,
//   and streams img*img pixels into the datapath as it requests them. It also
//   counts output rows and raises a sticky error flag on protocol violations.
//
// Ports
//   clk_i, reset_ni        clock, asynchronous active-low reset
//   start_i, abort_i       job start pulse; synchronous abort (any non-IDLE state)
//   kern_*_i               kernel coefficient write (accepted only in IDLE)
//   pix_valid_i/pix_data_i upstream pixel stream; pix_ready_o accepts it
//   conv_*                 datapath handshake: reset, pixel out, request,
//                          row-valid pulse, finish
//   ker_flat_o             kernel k coeff j at [(k*stride*stride+j)*(N+1) +: N+1]
//   row_cnt_o, busy_o, done_o, err_o   job status
module conv_job_sequencer #(
    parameter int N       = 7,
    parameter int stride  = 5,
    parameter int im      = 28,
    parameter int img     = 32,
    parameter int TIMEOUT = 4096
) (
    input  logic                              clk_i,
    input  logic                              reset_ni,
    input  logic                              start_i,
    input  logic                              abort_i,
    input  logic                              kern_wr_en_i,
    input  logic [2:0]                        kern_sel_i,
    input  logic [4:0]                        kern_idx_i,
    input  logic [N:0]                        kern_wdata_i,
    input  logic                              pix_valid_i,
    input  logic [N:0]                        pix_data_i,
    output logic                              pix_ready_o,
    output logic                              conv_reset_n_o,
    output logic [N:0]                        conv_data_o,
    output logic                              conv_data_valid_o,
    input  logic                              conv_data_request_i,
    input  logic                              conv_valid_i,
    input  logic                              conv_finish_i,
    output logic [6*stride*stride*(N+1)-1:0]  ker_flat_o,
    output logic [4:0]                        row_cnt_o,
    output logic                              busy_o,
    output logic                              done_o,
    output logic                              err_o
);
    localparam int KSZ  = stride * stride;
    localparam int NPIX = img * img;
    localparam int PW   = $clog2(NPIX + 1);
    localparam int DW   = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_CLR, S_STREAM, S_DRAIN, S_DONE, S_ABORT} state_e;

    state_e                  state_q, state_d;
    logic [PW-1:0]           pix_cnt_q, pix_cnt_d;
    logic [DW-1:0]           drain_cnt_q, drain_cnt_d;
    logic [4:0]              row_cnt_q, row_cnt_d;
    logic                    err_q, err_d;
    logic [N:0]              conv_data_q, conv_data_d;
    logic                    conv_data_valid_q, conv_data_valid_d;
    logic [5:0][KSZ-1:0][N:0] ker_q;

    logic kern_ok, kern_we, pix_acc;

    assign kern_ok = (kern_sel_i <= 3'd5) && (kern_idx_i < 5'(KSZ));
    assign kern_we = kern_wr_en_i && kern_ok && (state_q == S_IDLE);

    // Abort gates the handshake so upstream never sees a pixel taken in the
    // cycle the job is being torn down.
    assign pix_ready_o = (state_q == S_STREAM) && !abort_i && conv_data_request_i
                         && (pix_cnt_q < PW'(NPIX));
    assign pix_acc     = pix_valid_i && pix_ready_o;

    assign conv_reset_n_o    = !((state_q == S_CLR) || (state_q == S_ABORT));
    assign busy_o            = (state_q != S_IDLE);
    assign done_o            = (state_q == S_DONE) && !abort_i;
    assign conv_data_o       = conv_data_q;
    assign conv_data_valid_o = conv_data_valid_q;
    assign row_cnt_o         = row_cnt_q;
    assign err_o             = err_q;
    assign ker_flat_o        = ker_q;

    always_comb begin
        state_d           = state_q;
        pix_cnt_d         = pix_cnt_q;
        drain_cnt_d       = drain_cnt_q;
        row_cnt_d         = row_cnt_q;
        err_d             = err_q;
        conv_data_d       = conv_data_q;
        conv_data_valid_d = 1'b0;

        if (abort_i && state_q != S_IDLE) begin
            // abort overrides every other event this cycle, err included
            state_d = S_ABORT;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_d = S_CLR;
                        err_d   = 1'b0;
                    end
                end
                S_CLR: begin
                    state_d     = S_STREAM;
                    pix_cnt_d   = '0;
                    drain_cnt_d = '0;
                    row_cnt_d   = '0;
                    err_d       = 1'b0;
                end
                S_STREAM: begin
                    if (pix_acc) begin
                        conv_data_d       = pix_data_i;
                        conv_data_valid_d = 1'b1;
                        pix_cnt_d         = pix_cnt_q + 1'b1;
                    end
                    if (conv_finish_i) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (pix_acc && pix_cnt_q == PW'(NPIX - 1)) begin
                        state_d     = S_DRAIN;
                        drain_cnt_d = '0;
                    end
                end
                S_DRAIN: begin
                    if (conv_finish_i) begin
                        state_d = S_DONE;
                    end else if (drain_cnt_q == DW'(TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        drain_cnt_d = drain_cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (row_cnt_q != 5'(im)) err_d = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;   // S_ABORT
            endcase

            if (conv_valid_i && (state_q == S_STREAM || state_q == S_DRAIN)) begin
                if (row_cnt_q == 5'(im)) err_d = 1'b1;
                else                     row_cnt_d = row_cnt_q + 1'b1;
            end

            // Applied after the start clear so a bad write in the start cycle still flags.
            if (kern_wr_en_i && (!kern_ok || state_q != S_IDLE)) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q           <= S_IDLE;
            pix_cnt_q         <= '0;
            drain_cnt_q       <= '0;
            row_cnt_q         <= '0;
            err_q             <= 1'b0;
            conv_data_q       <= '0;
            conv_data_valid_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            pix_cnt_q         <= pix_cnt_d;
            drain_cnt_q       <= drain_cnt_d;
            row_cnt_q         <= row_cnt_d;
            err_q             <= err_d;
            conv_data_q       <= conv_data_d;
            conv_data_valid_q <= conv_data_valid_d;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            ker_q <= '0;
        end else if (kern_we) begin
            ker_q[kern_sel_i][kern_idx_i] <= kern_wdata_i;
        end
    end

endmodule

// File: tb/tb_conv_job_sequencer.sv
// Directed bench for conv_job_sequencer: kernel load/readback, full jobs with
// steady and gapped handshakes, premature finish, abort, row overflow, drain
// timeout and asynchronous reset mid-job.
module tb_conv_job_sequencer;
    localparam int NPIX    = 1024;
    localparam int TIMEOUT = 4096;
    localparam int LIMIT   = 8000;

    logic        clk, reset_n;
    logic        start, abort, kern_wr_en;
    logic [2:0]  kern_sel;
    logic [4:0]  kern_idx;
    logic [7:0]  kern_wdata;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        pix_ready;
    logic        conv_reset_n;
    logic [7:0]  conv_data;
    logic        conv_data_valid;
    logic        conv_data_request, conv_valid, conv_finish;
    logic [1199:0] ker_flat;
    logic [4:0]  row_cnt;
    logic        busy, done, err;

    int n_cmp = 0;
    int n_mis = 0;

    conv_job_sequencer dut (
        .clk_i(clk), .reset_ni(reset_n), .start_i(start), .abort_i(abort),
        .kern_wr_en_i(kern_wr_en), .kern_sel_i(kern_sel), .kern_idx_i(kern_idx),
        .kern_wdata_i(kern_wdata), .pix_valid_i(pix_valid), .pix_data_i(pix_data),
        .pix_ready_o(pix_ready), .conv_reset_n_o(conv_reset_n), .conv_data_o(conv_data),
        .conv_data_valid_o(conv_data_valid), .conv_data_request_i(conv_data_request),
        .conv_valid_i(conv_valid), .conv_finish_i(conv_finish), .ker_flat_o(ker_flat),
        .row_cnt_o(row_cnt), .busy_o(busy), .done_o(done), .err_o(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pixv(input int i);
        return 8'(i * 37 + 11);
    endfunction

    function automatic logic [7:0] kv(input int j);
        return 8'(j * 9 + 129);
    endfunction

    task automatic kwrite(input logic [2:0] s, input logic [4:0] i, input logic [7:0] d);
        kern_wr_en = 1'b1; kern_sel = s; kern_idx = i; kern_wdata = d;
        @(negedge clk);
        kern_wr_en = 1'b0;
    endtask

    // One job from start to return to IDLE, with a small datapath model:
    // rows are pulsed once all pixels are sent, then finish (optional).
    task automatic run_job(input bit rnd, input bit kw_start, input int fin_at,
                           input int abort_at, input int kw_at, input int nrows,
                           input bit send_fin, output int rx, output int oerr,
                           output int ndone, output int nrst, output int rdy_after,
                           output int drain_lat, output logic err_early);
        int  tx = 0, rows = 0, it = 0, drain_it = -1;
        bit  fin_done = 0, ab_done = 0, kw_done = 0, fin = 0;
        rx = 0; oerr = 0; ndone = 0; nrst = 0; rdy_after = 0; drain_lat = -1; err_early = 1'bx;
        start = 1'b1;
        if (kw_start) begin
            kern_wr_en = 1'b1; kern_sel = 3'd2; kern_idx = 5'd3; kern_wdata = 8'h3C;
        end
        while (!fin && it < LIMIT) begin
            @(negedge clk);
            if (conv_data_valid) begin
                if (conv_data !== pixv(rx)) oerr++;
                rx++;
            end
            if (!conv_reset_n) nrst++;
            if (it == 1) err_early = err;
            start = 0; kern_wr_en = 0; abort = 0; conv_valid = 0; conv_finish = 0;
            if (kw_at >= 0 && tx == kw_at && !kw_done) begin
                kern_wr_en = 1; kern_sel = 3'd0; kern_idx = 5'd0; kern_wdata = 8'h5A; kw_done = 1;
            end
            if (abort_at >= 0 && tx == abort_at && !ab_done) begin
                abort = 1; ab_done = 1;
            end
            if (fin_at >= 0 && tx >= fin_at && !fin_done) begin
                conv_finish = 1; fin_done = 1;
            end
            if (tx >= NPIX) begin
                if (drain_it < 0) drain_it = it;
                if (rows < nrows) begin
                    conv_valid = 1; rows++;
                end else if (send_fin && !fin_done) begin
                    conv_finish = 1; fin_done = 1;
                end
            end
            pix_valid         = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            conv_data_request = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            pix_data          = pixv(tx);
            #1;
            if (tx >= NPIX && pix_ready) rdy_after++;
            if (pix_valid && pix_ready) tx++;
            if (done) begin
                ndone++;
                drain_lat = it - drain_it;
            end
            if (it > 0 && !busy) fin = 1;
            it++;
        end
        if (!fin) chk("job_bound", 1, 0);
        pix_valid = 0; conv_data_request = 0; conv_valid = 0; conv_finish = 0;
        abort = 0; kern_wr_en = 0;
        @(negedge clk);
    endtask

    initial begin
        int rx, oerr, ndone, nrst, rdy, lat;
        logic eearly;
        reset_n = 0; start = 0; abort = 0; kern_wr_en = 0; kern_sel = 0; kern_idx = 0;
        kern_wdata = 0; pix_valid = 0; pix_data = 0; conv_data_request = 0;
        conv_valid = 0; conv_finish = 0;
        repeat (3) @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", pix_ready, 0);
        chk("rst_cdv", conv_data_valid, 0);
        chk("rst_cdata", conv_data, 0);
        chk("rst_rows", row_cnt, 0);
        chk("rst_convrst", conv_reset_n, 1);
        chk("rst_ker", |ker_flat, 0);

        // kernel load and readback
        for (int j = 0; j < 25; j++) kwrite(3'd0, 5'(j), kv(j));
        kwrite(3'd5, 5'd24, 8'h7F);
        @(negedge clk);
        for (int j = 0; j < 25; j++) chk($sformatf("ker0_%0d", j), ker_flat[j*8 +: 8], kv(j));
        chk("ker5_24", ker_flat[1199:1192], 8'h7F);
        chk("ker_zero", |ker_flat[1191:200], 0);
        chk("ker_err0", err, 0);
        kwrite(3'd6, 5'd0, 8'hFF);
        chk("bad_sel_err", err, 1);
        kwrite(3'd1, 5'd25, 8'hFF);
        @(negedge clk);
        chk("bad_idx_ker", |ker_flat[1191:200], 0);

        // job A: steady handshake, kernel write in the start cycle
        run_job(0, 1, -1, -1, -1, 28, 1, rx, oerr, ndone, nrst, rdy, lat, eearly);
        chk("A_rx", rx, NPIX);
        chk("A_order", oerr, 0);
        chk("A_nrst", nrst, 1);
        chk("A_done", ndone, 1);
        chk("A_rows", row_cnt, 28);
        chk("A_err", err, 0);
        chk("A_rdy_after", rdy, 0);
        chk("A_busy", busy, 0);
        chk("A_kw_start", ker_flat[(2*25+3)*8 +: 8], 8'h3C);

        // job B: random gaps on both sides
        run_job(1, 0, -1, -1, -1, 28, 1, rx, oerr, ndone, nrst, rdy, lat, eearly);
        chk("B_rx", rx, NPIX);
        chk("B_order", oerr, 0);
        chk("B_rdy_after", rdy, 0);
        chk("B_done", ndone, 1);
        chk("B_err", err, 0);

        // job C: premature finish
        run_job(0, 0, 500, -1, -1, 0, 0, rx, oerr, ndone, nrst, rdy, lat, eearly);
        chk("C_done", ndone, 1);
        chk("C_err", err, 1);

        // job D: start clears err, kernel write in STREAM, abort at pixel 300
        run_job(0, 0, -1, 300, 100, 0, 0, rx, oerr, ndone, nrst, rdy, lat, eearly);
        chk("D_err_clear", eearly, 0);
        chk("D_rx", rx, 300);
        chk("D_nrst", nrst, 2);
        chk("D_done", ndone, 0);
        chk("D_busy", busy, 0);
        chk("D_err", err, 1);
        chk("D_ker_kept", ker_flat[7:0], kv(0));

        // job E: 29th row pulse
        run_job(0, 0, -1, -1, -1, 29, 1, rx, oerr, ndone, nrst, rdy, lat, eearly);
        chk("E_rows", row_cnt, 28);
        chk("E_err", err, 1);
        chk("E_done", ndone, 1);

        // job F: no finish, drain timeout
        run_job(0, 0, -1, -1, -1, 28, 0, rx, oerr, ndone, nrst, rdy, lat, eearly);
        chk("F_done", ndone, 1);
        chk("F_lat", lat, TIMEOUT);
        chk("F_err", err, 1);

        // async reset mid-job
        start = 1;
        @(negedge clk);
        start = 0; pix_valid = 1; conv_data_request = 1;
        repeat (20) @(negedge clk);
        chk("M_busy_pre", busy, 1);
        #2 reset_n = 0;
        #1;
        chk("M_busy", busy, 0);
        chk("M_convrst", conv_reset_n, 1);
        chk("M_cdv", conv_data_valid, 0);
        chk("M_ready", pix_ready, 0);
        chk("M_ker", |ker_flat, 0);
        chk("M_err", err, 0);
        @(negedge clk);
        reset_n = 1; pix_valid = 0; conv_data_request = 0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
